// File: rtl/proc_pkg.sv
// proc_pkg
// Shared definitions for the instruction dispatcher: processor opcode
// constants, the dispatcher FSM state type, the instruction word layout
// {opcode[23:16], operand1[15:8], operand2[7:0]} and the values written to
// the result buffer when the processor never answers.
package proc_pkg;

   localparam logic [7:0] OP_MOV  = 8'h0D;
   localparam logic [7:0] OP_HALT = 8'hFF;

   localparam int INSTR_W = 24;
   localparam int FIELD_W = 8;
   localparam int OPC_LSB = 16;
   localparam int OP1_LSB = 8;
   localparam int OP2_LSB = 0;

   localparam logic [7:0] RES_TIMEOUT = 8'h00;
   localparam logic [3:0] FLG_TIMEOUT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_SETTLE,
      S_WAIT,
      S_CAPTURE,
      S_DONE
   } state_t;

endpackage

// File: rtl/dispatch_ram.sv
// dispatch_ram
// Simple dual-port RAM: one synchronous write port and one registered read
// port, shaped for block-RAM inference. A read of the address being written
// in the same cycle returns the old contents.
// Ports:
//   clk, reset     clock and synchronous active-high reset (read register only)
//   we/waddr/wdata write port
//   raddr/rdata    read port, rdata valid one cycle after raddr
module dispatch_ram #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately not reset; only the output register is.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= '0;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instr_dispatcher.sv
// instr_dispatcher
// Initiator side of the processor opcode/operand/ready handshake. A host
// loads a program into the instruction memory, then pulses start. Each word
// is fetched, issued on the opcode/operand outputs, given SETTLE cycles for
// any stale ready to clear, then waited on for up to TIMEOUT cycles. The
// processor's result and flags (or a timeout fill value) land in the result
// buffer at the instruction's index, readable by the host.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   start, prog_len                  run request and program length
//   prog_we, prog_addr, prog_wdata   instruction memory write port
//   opcode_out, operand1_out,
//   operand2_out                     instruction fields to the processor
//   ula_ready_in, result_in,
//   flags_in                         processor response
//   rd_addr, rd_result, rd_flags     result buffer read port (1-cycle latency)
//   busy, done, timeout_err, pc_out  run status
module instr_dispatcher
   import proc_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int SETTLE  = 2,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   prog_len,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [23:0]       prog_wdata,
   output logic [7:0]        opcode_out,
   output logic [7:0]        operand1_out,
   output logic [7:0]        operand2_out,
   input  logic              ula_ready_in,
   input  logic [7:0]        result_in,
   input  logic [3:0]        flags_in,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_result,
   output logic [3:0]        rd_flags,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output logic [ADDR_W-1:0] pc_out
);

   localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

   state_t              state_reg, state_next;
   logic [ADDR_W-1:0]   pc_reg, pc_next;
   logic [ADDR_W:0]     len_reg, len_next;
   logic [7:0]          cnt_reg, cnt_next;      // settle counter, then wait counter
   logic                to_reg, to_next;        // current instruction timed out
   logic [7:0]          opcode_reg, opcode_next;
   logic [7:0]          op1_reg, op1_next;
   logic [7:0]          op2_reg, op2_next;
   logic                busy_reg, busy_next;
   logic                done_reg, done_next;
   logic                terr_reg, terr_next;

   logic [INSTR_W-1:0]  instr;
   logic                imem_we;
   logic                rbuf_we;
   logic [11:0]         rbuf_wdata;
   logic [11:0]         rbuf_rdata;
   logic [ADDR_W:0]     pc_inc;

   // Program writes are only honoured while idle, so a running program
   // cannot be modified underneath itself.
   assign imem_we = prog_we && (state_reg == S_IDLE);
   assign pc_inc  = {1'b0, pc_reg} + (ADDR_W+1)'(1);

   dispatch_ram #(
      .WIDTH  (INSTR_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) imem (
      .clk   (clk),
      .reset (reset),
      .we    (imem_we),
      .waddr (prog_addr),
      .wdata (prog_wdata),
      .raddr (pc_reg),
      .rdata (instr)
   );

   dispatch_ram #(
      .WIDTH  (12),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) rbuf (
      .clk   (clk),
      .reset (reset),
      .we    (rbuf_we),
      .waddr (pc_reg),
      .wdata (rbuf_wdata),
      .raddr (rd_addr),
      .rdata (rbuf_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= S_IDLE;
         pc_reg     <= '0;
         len_reg    <= '0;
         cnt_reg    <= '0;
         to_reg     <= 1'b0;
         opcode_reg <= '0;
         op1_reg    <= '0;
         op2_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
         terr_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pc_reg     <= pc_next;
         len_reg    <= len_next;
         cnt_reg    <= cnt_next;
         to_reg     <= to_next;
         opcode_reg <= opcode_next;
         op1_reg    <= op1_next;
         op2_reg    <= op2_next;
         busy_reg   <= busy_next;
         done_reg   <= done_next;
         terr_reg   <= terr_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      pc_next     = pc_reg;
      len_next    = len_reg;
      cnt_next    = cnt_reg;
      to_next     = to_reg;
      opcode_next = opcode_reg;
      op1_next    = op1_reg;
      op2_next    = op2_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      terr_next   = terr_reg;
      rbuf_we     = 1'b0;
      rbuf_wdata  = {result_in, flags_in};

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               len_next  = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
               pc_next   = '0;
               busy_next = 1'b1;
               terr_next = 1'b0;
               state_next = (prog_len == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            state_next = S_ISSUE;
         end
         S_ISSUE: begin
            // HALT ends the run without disturbing the processor outputs.
            if (instr[OPC_LSB +: FIELD_W] == OP_HALT) begin
               state_next = S_DONE;
            end else begin
               opcode_next = instr[OPC_LSB +: FIELD_W];
               op1_next    = instr[OP1_LSB +: FIELD_W];
               op2_next    = instr[OP2_LSB +: FIELD_W];
               cnt_next    = '0;
               to_next     = 1'b0;
               state_next  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            // Ready is ignored here: it may still be the previous op's pulse.
            if (cnt_reg == 8'(SETTLE - 1)) begin
               cnt_next   = '0;
               state_next = S_WAIT;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         S_WAIT: begin
            // Ready on the final allowed cycle still counts as an answer.
            if (ula_ready_in) begin
               state_next = S_CAPTURE;
            end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
               to_next    = 1'b1;
               state_next = S_CAPTURE;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         S_CAPTURE: begin
            rbuf_we = 1'b1;
            if (to_reg) begin
               rbuf_wdata = {RES_TIMEOUT, FLG_TIMEOUT};
               terr_next  = 1'b1;
            end
            if (pc_inc == len_reg) begin
               state_next = S_DONE;
            end else begin
               pc_next    = pc_inc[ADDR_W-1:0];
               state_next = S_FETCH;
            end
         end
         S_DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign opcode_out   = opcode_reg;
   assign operand1_out = op1_reg;
   assign operand2_out = op2_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign timeout_err  = terr_reg;
   assign pc_out       = pc_reg;
   assign rd_result    = rbuf_rdata[11:4];
   assign rd_flags     = rbuf_rdata[3:0];

endmodule

// File: tb/tb_instr_dispatcher.sv
// tb_instr_dispatcher
// Self-checking bench for instr_dispatcher. A behavioural responder plays
// the processor (result = op1 + op2, flags = 0) with ready always high,
// never high, or a single pulse a chosen number of cycles after the
// operands change. Expected results, timeouts and run lengths come from a
// cycle-budget model of each instruction.
module tb_instr_dispatcher;
   import proc_pkg::*;

   localparam int SETTLE  = 2;
   localparam int TIMEOUT = 15;
   localparam int PUL = 0;
   localparam int ALW = 1;
   localparam int NEV = 2;

   logic        clk = 1'b0;
   logic        reset, start, prog_we, ula_ready_in;
   logic [4:0]  prog_len;
   logic [3:0]  prog_addr, rd_addr;
   logic [23:0] prog_wdata;
   logic [7:0]  result_in;
   logic [3:0]  flags_in;
   logic [7:0]  opcode_out, operand1_out, operand2_out, rd_result;
   logic [3:0]  rd_flags, pc_out;
   logic        busy, done, timeout_err;

   int errors = 0;
   int checks = 0;

   // responder state
   int          resp_mode = ALW;
   int          delay_tab [256];
   int          issue_count = 0;
   logic [23:0] prev_ops = '0;
   int          rcnt = 0;
   int          cur_delay = 0;
   bit          armed = 1'b0;

   // result buffer model
   logic [7:0] m_res [16];
   logic [3:0] m_flg [16];
   bit         m_valid [16];

   always #5 clk = ~clk;

   instr_dispatcher dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .prog_len     (prog_len),
      .prog_we      (prog_we),
      .prog_addr    (prog_addr),
      .prog_wdata   (prog_wdata),
      .opcode_out   (opcode_out),
      .operand1_out (operand1_out),
      .operand2_out (operand2_out),
      .ula_ready_in (ula_ready_in),
      .result_in    (result_in),
      .flags_in     (flags_in),
      .rd_addr      (rd_addr),
      .rd_result    (rd_result),
      .rd_flags     (rd_flags),
      .busy         (busy),
      .done         (done),
      .timeout_err  (timeout_err),
      .pc_out       (pc_out)
   );

   always @(negedge clk) begin
      logic [23:0] cur;
      cur = {opcode_out, operand1_out, operand2_out};
      ula_ready_in = (resp_mode == ALW);
      if (cur !== prev_ops) begin
         prev_ops  = cur;
         result_in = operand1_out + operand2_out;
         flags_in  = 4'h0;
         cur_delay = delay_tab[issue_count % 256];
         issue_count++;
         rcnt  = 0;
         armed = 1'b1;
      end else if (armed) begin
         rcnt++;
      end
      if (resp_mode == PUL && armed && rcnt == cur_delay) begin
         ula_ready_in = 1'b1;
         armed = 1'b0;
      end
   end

   // WAIT cycles an instruction spends given the responder behaviour; the
   // pulse at delay d lands in WAIT cycle d-SETTLE+1 when that is in range.
   function automatic int wait_cycles(int mode, int d);
      if (mode == ALW) return 1;
      if (mode == NEV) return TIMEOUT;
      if (d >= SETTLE && d <= SETTLE + TIMEOUT - 1) return d - SETTLE + 1;
      return TIMEOUT;
   endfunction

   function automatic bit times_out(int mode, int d);
      if (mode == ALW) return 1'b0;
      if (mode == NEV) return 1'b1;
      return !(d >= SETTLE && d <= SETTLE + TIMEOUT - 1);
   endfunction

   function automatic void model_set(int a, logic [23:0] w, bit to);
      m_res[a]   = to ? 8'h00 : (w[15:8] + w[7:0]);
      m_flg[a]   = to ? 4'hF : 4'h0;
      m_valid[a] = 1'b1;
   endfunction

   task automatic load_word(input int a, input logic [23:0] w);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a[3:0]; prog_wdata = w;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic read_rbuf(input int a, output logic [7:0] r, output logic [3:0] f);
      @(negedge clk);
      rd_addr = a[3:0];
      @(negedge clk);
      r = rd_result; f = rd_flags;
   endtask

   // lat = clock edges after the start-sampling edge until done is seen.
   task automatic run_prog(input int len, input bit wr, input logic [3:0] wa,
                           input logic [23:0] wd, input int budget,
                           output int lat, output int pulses);
      @(negedge clk);
      prog_len = len[4:0]; start = 1'b1;
      if (wr) begin
         prog_we = 1'b1; prog_addr = wa; prog_wdata = wd;
      end
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      pulses = (done === 1'b1) ? 1 : 0;
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({opcode_out, operand1_out, operand2_out} !== 24'h0) begin errors++; $display("FAIL reset_ops: got %h need 000000", {opcode_out, operand1_out, operand2_out}); end
      checks++; if ({busy, done, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b need 000", {busy, done, timeout_err}); end
      checks++; if (pc_out !== 4'h0) begin errors++; $display("FAIL reset_pc: got %h need 0", pc_out); end
      checks++; if ({rd_result, rd_flags} !== 12'h0) begin errors++; $display("FAIL reset_rd: got %h need 000", {rd_result, rd_flags}); end
      reset = 1'b0;
      @(negedge clk);
      $display("reset: checked idle outputs");
   endtask

   task automatic test_basic();
      int lat, pulses, base;
      logic [7:0] r; logic [3:0] f;
      load_word(0, 24'h010503);
      load_word(1, 24'h011020);
      base = issue_count;
      delay_tab[base % 256] = 3; delay_tab[(base + 1) % 256] = 3;
      resp_mode = PUL;
      model_set(0, 24'h010503, 1'b0); model_set(1, 24'h011020, 1'b0);
      run_prog(2, 1'b0, 4'h0, 24'h0, 200, lat, pulses);
      checks++; if (lat != 15) begin errors++; $display("FAIL basic_latency: got %0d need 15", lat); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL basic_done_pulses: got %0d need 1", pulses); end
      checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL basic_status: busy=%b terr=%b need 0 0", busy, timeout_err); end
      read_rbuf(0, r, f);
      checks++; if ({r, f} !== 12'h080) begin errors++; $display("FAIL basic_rbuf0: got %h need 080", {r, f}); end
      read_rbuf(1, r, f);
      checks++; if ({r, f} !== 12'h300) begin errors++; $display("FAIL basic_rbuf1: got %h need 300", {r, f}); end
      $display("basic: two instructions, latency %0d", lat);
   endtask

   task automatic test_ready_high();
      int lat, pulses;
      logic [7:0] r; logic [3:0] f;
      logic [23:0] w [3];
      w[0] = 24'h021122; w[1] = {OP_MOV, 16'h4001}; w[2] = 24'h037F81;
      for (int i = 0; i < 3; i++) begin
         load_word(i, w[i]);
         model_set(i, w[i], 1'b0);
      end
      resp_mode = ALW;
      run_prog(3, 1'b0, 4'h0, 24'h0, 200, lat, pulses);
      checks++; if (lat != 3 * (4 + SETTLE) + 1) begin errors++; $display("FAIL ready_high_latency: got %0d need %0d", lat, 3 * (4 + SETTLE) + 1); end
      for (int i = 0; i < 3; i++) begin
         read_rbuf(i, r, f);
         checks++; if ({r, f} !== {m_res[i], m_flg[i]}) begin errors++; $display("FAIL ready_high_rbuf%0d: got %h need %h", i, {r, f}, {m_res[i], m_flg[i]}); end
      end
      $display("ready_high: three instructions, latency %0d", lat);
   endtask

   task automatic test_timeout();
      int lat, pulses;
      logic [7:0] r; logic [3:0] f;
      logic [23:0] ops_before;
      load_word(0, 24'h040102);
      model_set(0, 24'h040102, 1'b1);
      resp_mode = NEV;
      run_prog(1, 1'b0, 4'h0, 24'h0, 200, lat, pulses);
      checks++; if (lat != 1 + 3 + SETTLE + TIMEOUT) begin errors++; $display("FAIL timeout_latency: got %0d need %0d", lat, 1 + 3 + SETTLE + TIMEOUT); end
      checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_err_set: got %b need 1", timeout_err); end
      checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_done: got %0d pulses need 1", pulses); end
      read_rbuf(0, r, f);
      checks++; if ({r, f} !== 12'h00F) begin errors++; $display("FAIL timeout_rbuf0: got %h need 00F", {r, f}); end
      // zero-length run: done two cycles after start, outputs untouched, error cleared
      ops_before = {opcode_out, operand1_out, operand2_out};
      run_prog(0, 1'b0, 4'h0, 24'h0, 50, lat, pulses);
      checks++; if (lat != 1 || pulses != 1) begin errors++; $display("FAIL zero_len_done: lat=%0d pulses=%0d need 1 1", lat, pulses); end
      checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_err_clear: got %b need 0", timeout_err); end
      checks++; if ({opcode_out, operand1_out, operand2_out} !== ops_before) begin errors++; $display("FAIL zero_len_ops: got %h need %h", {opcode_out, operand1_out, operand2_out}, ops_before); end
      $display("timeout: timed-out run and zero-length run");
   endtask

   task automatic test_halt();
      int lat, pulses;
      logic [7:0] r; logic [3:0] f;
      load_word(0, 24'h050901);
      load_word(1, {OP_HALT, 16'h1234});
      model_set(0, 24'h050901, 1'b0);
      resp_mode = ALW;
      run_prog(4, 1'b0, 4'h0, 24'h0, 200, lat, pulses);
      checks++; if (lat != (4 + SETTLE) + 3) begin errors++; $display("FAIL halt_latency: got %0d need %0d", lat, 4 + SETTLE + 3); end
      checks++; if (opcode_out !== 8'h05 || pc_out !== 4'h1) begin errors++; $display("FAIL halt_outputs: opcode=%h pc=%h need 05 1", opcode_out, pc_out); end
      for (int i = 0; i < 4; i++) begin
         if (m_valid[i]) begin
            read_rbuf(i, r, f);
            checks++; if ({r, f} !== {m_res[i], m_flg[i]}) begin errors++; $display("FAIL halt_rbuf%0d: got %h need %h", i, {r, f}, {m_res[i], m_flg[i]}); end
         end
      end
      $display("halt: stopped at pc 1, latency %0d", lat);
   endtask

   task automatic test_busy_ignore();
      int lat, pulses;
      logic [7:0] r; logic [3:0] f;
      load_word(0, 24'h062003);
      model_set(0, 24'h062003, 1'b0);
      resp_mode = ALW;
      @(negedge clk);
      prog_len = 5'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_set: got %b need 1", busy); end
      prog_we = 1'b1; prog_addr = 4'h0; prog_wdata = 24'h075050; start = 1'b1; prog_prog_dummy();
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++; if (lat != 4 + SETTLE + 1) begin errors++; $display("FAIL busy_latency: got %0d need %0d", lat, 4 + SETTLE + 1); end
      repeat (4) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_clear: got %b need 0", busy); end
      // rerun without reloading: the write during busy must not have landed
      run_prog(1, 1'b0, 4'h0, 24'h0, 100, lat, pulses);
      checks++; if (opcode_out !== 8'h06) begin errors++; $display("FAIL busy_write_ignored: opcode %h need 06", opcode_out); end
      read_rbuf(0, r, f);
      checks++; if ({r, f} !== 12'h230) begin errors++; $display("FAIL busy_rbuf0: got %h need 230", {r, f}); end
      $display("busy_ignore: start and write during run ignored");
   endtask

   // empty task marking the point where the busy-time drives are applied
   task automatic prog_prog_dummy();
   endtask

   task automatic test_same_cycle();
      int lat, pulses;
      logic [7:0] r; logic [3:0] f;
      load_word(0, 24'h0A0000);
      model_set(0, 24'h080F01, 1'b0);
      resp_mode = ALW;
      run_prog(1, 1'b1, 4'h0, 24'h080F01, 100, lat, pulses);
      checks++; if (opcode_out !== 8'h08) begin errors++; $display("FAIL same_cycle_opcode: got %h need 08", opcode_out); end
      read_rbuf(0, r, f);
      checks++; if ({r, f} !== 12'h100) begin errors++; $display("FAIL same_cycle_rbuf0: got %h need 100", {r, f}); end
      $display("same_cycle: write plus start fetched new word");
   endtask

   task automatic test_reset_mid_run();
      int lat, pulses;
      logic [7:0] r; logic [3:0] f;
      load_word(0, 24'h0A0B0C);
      resp_mode = NEV;
      @(negedge clk);
      prog_len = 5'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);      // now in the second WAIT cycle
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if ({busy, done, timeout_err} !== 3'b000) begin errors++; $display("FAIL midreset_status: got %b need 000", {busy, done, timeout_err}); end
      checks++; if ({opcode_out, operand1_out, operand2_out, pc_out, rd_result, rd_flags} !== 40'h0) begin errors++; $display("FAIL midreset_outputs: got %h need 0", {opcode_out, operand1_out, operand2_out, pc_out, rd_result, rd_flags}); end
      pulses = 0;
      repeat (25) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      checks++; if (pulses != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses need 0", pulses); end
      read_rbuf(0, r, f);
      checks++; if ({r, f} !== {m_res[0], m_flg[0]}) begin errors++; $display("FAIL midreset_rbuf_kept: got %h need %h", {r, f}, {m_res[0], m_flg[0]}); end
      resp_mode = ALW;
      model_set(0, 24'h0A0B0C, 1'b0);
      run_prog(1, 1'b0, 4'h0, 24'h0, 100, lat, pulses);
      checks++; if (lat != 4 + SETTLE + 1 || pc_out !== 4'h0) begin errors++; $display("FAIL midreset_rerun: lat=%0d pc=%h need %0d 0", lat, pc_out, 4 + SETTLE + 1); end
      read_rbuf(0, r, f);
      checks++; if ({r, f} !== 12'h170) begin errors++; $display("FAIL midreset_rerun_rbuf0: got %h need 170", {r, f}); end
      $display("reset_mid_run: aborted cleanly and reran");
   endtask

   task automatic test_random();
      logic [23:0] w, prev;
      int n, len, lat, pulses, exp_lat, base, d;
      bit to, any_to;
      logic [7:0] r; logic [3:0] f;
      resp_mode = PUL;
      prev = {opcode_out, operand1_out, operand2_out};
      for (int it = 0; it < 6; it++) begin
         n = (it == 0) ? 16 : int'($urandom_range(1, 16));
         len = (n == 16) ? 16 + int'($urandom_range(0, 15)) : n;
         base = issue_count;
         exp_lat = 1;
         any_to = 1'b0;
         for (int i = 0; i < n; i++) begin
            do begin
               w = 24'($urandom);
               if (w[23:16] == OP_HALT || $urandom_range(0, 3) == 0) w[23:16] = OP_MOV;
            end while (w == prev);
            prev = w;
            load_word(i, w);
            d = int'($urandom_range(0, 20));
            delay_tab[(base + i) % 256] = d;
            exp_lat += 3 + SETTLE + wait_cycles(PUL, d);
            to = times_out(PUL, d);
            any_to |= to;
            model_set(i, w, to);
         end
         run_prog(len, 1'b0, 4'h0, 24'h0, 800, lat, pulses);
         checks++; if (lat != exp_lat || pulses != 1) begin errors++; $display("FAIL random%0d_run: lat=%0d pulses=%0d need %0d 1", it, lat, pulses, exp_lat); end
         checks++; if (timeout_err !== any_to) begin errors++; $display("FAIL random%0d_terr: got %b need %b", it, timeout_err, any_to); end
         for (int i = 0; i < n; i++) begin
            read_rbuf(i, r, f);
            checks++; if ({r, f} !== {m_res[i], m_flg[i]}) begin errors++; $display("FAIL random%0d_rbuf%0d: got %h need %h", it, i, {r, f}, {m_res[i], m_flg[i]}); end
         end
         $display("random: iteration %0d, %0d instructions, prog_len %0d, latency %0d", it, n, len, lat);
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_len = '0;
      prog_addr = '0; prog_wdata = '0; rd_addr = '0;
      for (int i = 0; i < 256; i++) delay_tab[i] = 0;
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      test_reset();
      test_basic();
      test_ready_high();
      test_timeout();
      test_halt();
      test_busy_ignore();
      test_same_cycle();
      test_reset_mid_run();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
